seq_left_normalizer: RTL

- Iterative left normalizer that produces the control word for the one-hot right barrel shifter in this codebase.
- Takes a WIDTH-bit word and shifts it left one bit per clock until its MSB is 1.
- Reports the normalized word, the shift count (binary and one-hot), and a zero flag.
- Feeding dout and n_onehot into the right barrel shifter (W[i]=D[i+k], ground fill) reproduces din exactly.

---
 rtl/seq_left_normalizer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/seq_left_normalizer.sv
// seq_left_normalizer: iterative left normalizer, one shift per clock.
// Produces the normalized word, its shift count (binary and one-hot) and
// a zero flag; dout and n_onehot together drive the one-hot right barrel
// shifter to reconstruct the original word.
module seq_left_normalizer #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    shamt,
    output logic [WIDTH-1:0] n_onehot,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work_reg;
    logic [WIDTH-1:0] work_next;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] dout_next;
    logic [CW-1:0]    shamt_next;
    logic [WIDTH-1:0] onehot_next;
    logic             zero_next;

    // Next-state, datapath updates and the busy/done status decoded from state.
    always_comb begin
        state_next  = state;
        work_next   = work_reg;
        count_next  = count;
        dout_next   = dout;
        shamt_next  = shamt;
        onehot_next = n_onehot;
        zero_next   = zero;
        busy        = 1'b0;
        done        = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    work_next  = din;
                    count_next = '0;
                    zero_next  = 1'b0;
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                busy = 1'b1;
                if (work_reg == '0) begin
                    zero_next   = 1'b1;
                    dout_next   = '0;
                    shamt_next  = '0;
                    onehot_next = ONE;
                    state_next  = DONE;
                end else if (work_reg[WIDTH-1]) begin
                    dout_next   = work_reg;
                    shamt_next  = count;
                    onehot_next = ONE << count;
                    state_next  = DONE;
                end else begin
                    work_next  = {work_reg[WIDTH-2:0], 1'b0};
                    count_next = count + CW'(1);
                end
            end

            DONE: begin
                done = 1'b1;
                if (start) begin
                    work_next  = din;
                    count_next = '0;
                    zero_next  = 1'b0;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register; reset returns to IDLE and aborts any in-flight work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Working register, shift counter and held result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_reg <= '0;
            count    <= '0;
            dout     <= '0;
            shamt    <= '0;
            n_onehot <= '0;
            zero     <= 1'b0;
        end else begin
            work_reg <= work_next;
            count    <= count_next;
            dout     <= dout_next;
            shamt    <= shamt_next;
            n_onehot <= onehot_next;
            zero     <= zero_next;
        end
    end

endmodule
